// File: rtl/iir_coef_loader.sv
// Coefficient/order loader for the cascaded IIR filter: stages writes in a shadow
// bank, validates on the last beat, then commits atomically behind a filter flush.
module iir_coef_loader #(
  parameter int W            = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_last,
  input  logic         err_clr,
  output logic [W-1:0] b0,
  output logic [W-1:0] b1,
  output logic [W-1:0] b2,
  output logic [W-1:0] a1,
  output logic [W-1:0] a2,
  output logic [W-1:0] a3,
  output logic [3:0]   order,
  output logic         filt_reset,
  output logic         commit_done,
  output logic         cfg_err
);

  typedef enum logic [1:0] {LOAD, CHECK, FLUSH} state_e;

  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [5:0][W-1:0]   sh_coef_q, sh_coef_d;
  logic [5:0][W-1:0]   act_coef_q, act_coef_d;
  logic [3:0]          sh_order_q, sh_order_d;
  logic [3:0]          act_order_q, act_order_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                filt_reset_q, filt_reset_d;
  logic                commit_done_q, commit_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                bad_txn_q, bad_txn_d;
  logic                accept;
  logic                order_ok;

  // filt_reset_q is only low during reset and FLUSH, so gating LOAD with it keeps
  // ready low until the first edge after reset release without a separate flop.
  assign cfg_ready = (state_q == LOAD) && filt_reset_q;
  assign accept    = cfg_valid && cfg_ready;
  assign order_ok  = (sh_order_q >= 4'd1) && (sh_order_q <= 4'd3);

  always_comb begin
    state_d       = state_q;
    sh_coef_d     = sh_coef_q;
    act_coef_d    = act_coef_q;
    sh_order_d    = sh_order_q;
    act_order_d   = act_order_q;
    cnt_d         = cnt_q;
    filt_reset_d  = filt_reset_q;
    commit_done_d = 1'b0;
    cfg_err_d     = cfg_err_q && !err_clr;
    bad_txn_d     = bad_txn_q;
    case (state_q)
      LOAD: begin
        filt_reset_d = 1'b1;
        if (accept) begin
          if (cfg_addr == 3'd7) bad_txn_d = 1'b1;
          else if (cfg_addr == 3'd6) sh_order_d = cfg_data[3:0];
          for (int i = 0; i < 6; i++)
            if (cfg_addr == 3'(i)) sh_coef_d[i] = cfg_data;
          if (cfg_last) state_d = CHECK;
        end
      end
      CHECK: begin
        bad_txn_d = 1'b0;
        if (!bad_txn_q && order_ok) begin
          act_coef_d   = sh_coef_q;
          act_order_d  = sh_order_q;
          filt_reset_d = 1'b0;
          cnt_d        = FLUSH_INIT;
          state_d      = FLUSH;
        end else begin
          // set wins over a simultaneous err_clr
          cfg_err_d  = 1'b1;
          sh_coef_d  = act_coef_q;
          sh_order_d = act_order_q;
          state_d    = LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 8'd0) begin
          filt_reset_d  = 1'b1;
          commit_done_d = 1'b1;
          state_d       = LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= LOAD;
      sh_coef_q     <= '0;
      act_coef_q    <= '0;
      sh_order_q    <= '0;
      act_order_q   <= '0;
      cnt_q         <= '0;
      filt_reset_q  <= 1'b0;
      commit_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      bad_txn_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_coef_q     <= sh_coef_d;
      act_coef_q    <= act_coef_d;
      sh_order_q    <= sh_order_d;
      act_order_q   <= act_order_d;
      cnt_q         <= cnt_d;
      filt_reset_q  <= filt_reset_d;
      commit_done_q <= commit_done_d;
      cfg_err_q     <= cfg_err_d;
      bad_txn_q     <= bad_txn_d;
    end
  end

  assign b0          = act_coef_q[0];
  assign b1          = act_coef_q[1];
  assign b2          = act_coef_q[2];
  assign a1          = act_coef_q[3];
  assign a2          = act_coef_q[4];
  assign a3          = act_coef_q[5];
  assign order       = act_order_q;
  assign filt_reset  = filt_reset_q;
  assign commit_done = commit_done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_iir_coef_loader.sv
// Randomized + directed bench for iir_coef_loader against a transaction-level
// model of the shadow/active banks and the commit/reject timing.
module tb_iir_coef_loader;
  localparam int W  = 16;
  localparam int FC = 4;

  logic         clk = 1'b0;
  logic         reset, cfg_valid, cfg_ready, cfg_last, err_clr;
  logic [2:0]   cfg_addr;
  logic [W-1:0] cfg_data, b0, b1, b2, a1, a2, a3;
  logic [3:0]   order;
  logic         filt_reset, commit_done, cfg_err;

  iir_coef_loader #(.W(W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last), .err_clr(err_clr),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .a3(a3), .order(order),
    .filt_reset(filt_reset), .commit_done(commit_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: banks as plain arrays, transaction flags
  logic [W-1:0] sh_m [6];
  logic [W-1:0] act_m [6];
  logic [3:0]   sh_ord_m, act_ord_m;
  logic         bad_m, err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] dut_coef(input int i);
    case (i)
      0: return b0;
      1: return b1;
      2: return b2;
      3: return a1;
      4: return a2;
      default: return a3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin sh_m[i] = '0; act_m[i] = '0; end
    sh_ord_m = '0; act_ord_m = '0; bad_m = 0; err_m = 0;
  endtask

  task automatic chk_active(input string tag);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_c%0d", tag, i), 32'(dut_coef(i)), 32'(act_m[i]));
    chk({tag, "_order"}, 32'(order), 32'(act_ord_m));
  endtask

  // Present one beat, wait for ready (bounded), take the accepting edge.
  task automatic beat(input logic [2:0] addr, input logic [W-1:0] data, input logic last);
    int n = 0;
    cfg_valid = 1; cfg_addr = addr; cfg_data = data; cfg_last = last;
    while (!cfg_ready && n < 300) begin tick(); n++; end
    if (n >= 300) begin chk("ready_timeout", 0, 1); cfg_valid = 0; return; end
    tick();
    if (err_clr) err_m = 0;
    if (addr == 3'd7) bad_m = 1;
    else if (addr == 3'd6) sh_ord_m = data[3:0];
    else sh_m[addr] = data;
    cfg_valid = 0; cfg_last = 0;
  endtask

  // Called right after the last beat's accepting edge E; follows through to done.
  task automatic finish_txn(input string tag);
    logic commit;
    commit = !bad_m && (sh_ord_m >= 1) && (sh_ord_m <= 3);
    bad_m = 0;
    chk({tag, "_check_rdy"}, 32'(cfg_ready), 0);
    tick();
    if (commit) begin
      for (int i = 0; i < 6; i++) act_m[i] = sh_m[i];
      act_ord_m = sh_ord_m;
      if (err_clr) err_m = 0;
      chk_active(tag);
      chk({tag, "_frst_lo"}, 32'(filt_reset), 0);
      for (int k = 1; k < FC; k++) begin
        tick();
        chk({tag, "_flush_lo"}, 32'(filt_reset), 0);
        chk({tag, "_flush_rdy"}, 32'(cfg_ready), 0);
        chk({tag, "_flush_done"}, 32'(commit_done), 0);
      end
      tick();
      chk({tag, "_frst_hi"}, 32'(filt_reset), 1);
      chk({tag, "_done"}, 32'(commit_done), 1);
      chk({tag, "_rdy"}, 32'(cfg_ready), 1);
    end else begin
      err_m = 1;
      for (int i = 0; i < 6; i++) sh_m[i] = act_m[i];
      sh_ord_m = act_ord_m;
      chk({tag, "_err"}, 32'(cfg_err), 1);
      chk({tag, "_rej_rdy"}, 32'(cfg_ready), 1);
      chk({tag, "_rej_frst"}, 32'(filt_reset), 1);
      chk({tag, "_rej_done"}, 32'(commit_done), 0);
      chk_active(tag);
    end
    chk({tag, "_errflag"}, 32'(cfg_err), 32'(err_m));
  endtask

  initial begin
    reset = 0; cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_last = 0; err_clr = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_frst", 32'(filt_reset), 0);
    chk("rst_rdy", 32'(cfg_ready), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk_active("rst");
    reset = 1;
    tick();
    chk("rel_frst", 32'(filt_reset), 1);
    chk("rel_rdy", 32'(cfg_ready), 1);

    // full load
    for (int i = 0; i < 6; i++) beat(3'(i), 16'h0101 * 16'(i + 1), 0);
    beat(3'd6, 16'h0002, 1);
    finish_txn("full");
    chk("full_ord2", 32'(order), 2);

    // partial update
    beat(3'd1, 16'h7fff, 1);
    finish_txn("part");
    chk("part_b1", 32'(b1), 32'h7fff);

    // illegal order, then partial b0 commits with order 2
    beat(3'd6, 16'h0000, 1);
    finish_txn("badord");
    beat(3'd0, 16'hbeef, 1);
    finish_txn("afterbad");
    chk("afterbad_ord", 32'(order), 2);

    // illegal address
    beat(3'd7, 16'h5555, 0);
    beat(3'd0, 16'h1234, 1);
    finish_txn("badaddr");
    chk("badaddr_b0", 32'(b0), 32'hbeef);

    // err_clr clears at the last-beat edge, but the reject set in CHECK wins
    err_clr = 1;
    beat(3'd6, 16'h0009, 1);
    chk("errclr_cleared", 32'(cfg_err), 0);
    finish_txn("errclr_set");
    tick();
    err_m = 0;
    err_clr = 0;
    chk("errclr_clear", 32'(cfg_err), 0);

    // backpressure: second transaction held during CHECK/FLUSH
    beat(3'd2, 16'hc0de, 1);
    cfg_valid = 1; cfg_addr = 3'd3; cfg_data = 16'h0a0a; cfg_last = 1;
    finish_txn("bp1");
    beat(3'd3, 16'h0a0a, 1);
    finish_txn("bp2");

    // randomized transactions
    for (int t = 0; t < 60; t++) begin
      int nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        logic [2:0] ad;
        logic [W-1:0] dt;
        ad = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        dt = 16'($urandom);
        if (ad == 3'd6) dt[3:0] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, 3));
        beat(ad, dt, k == nb - 1);
      end
      finish_txn("rnd");
      repeat ($urandom_range(0, 2)) tick();
    end

    // reset during the third FLUSH cycle
    beat(3'd4, 16'h4444, 1);
    tick();
    chk("mid_frst", 32'(filt_reset), 0);
    tick(); tick();
    reset = 0;
    tick();
    model_reset();
    chk_active("midrst");
    chk("midrst_frst", 32'(filt_reset), 0);
    chk("midrst_done", 32'(commit_done), 0);
    chk("midrst_rdy", 32'(cfg_ready), 0);
    chk("midrst_err", 32'(cfg_err), 0);
    reset = 1;
    tick();
    chk("midrel_frst", 32'(filt_reset), 1);
    chk("midrel_done", 32'(commit_done), 0);
    chk("midrel_rdy", 32'(cfg_ready), 1);
    tick();
    chk("midrel_done2", 32'(commit_done), 0);

    // shadow was cleared too: a lone coefficient write has order 0 and is rejected
    beat(3'd0, 16'h1111, 1);
    finish_txn("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iir_coef_loader.md
# iir_coef_loader

Configuration front end for the cascaded IIR filter. Accepts coefficient and order writes over a valid/ready beat interface into a shadow bank, validates the transaction, then atomically commits it to the active coefficient/order outputs that drive the filter. During the commit it holds the filter in reset for a fixed flush window so no sample is computed with a mix of old and new coefficients.

## Interface
- `W`, 16: coefficient width.
- `FLUSH_CYCLES`, 4: cycles the filter reset is held low per commit. Legal range is 1..255.

- `clk`  in  1: sole clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-low reset.
- `cfg_valid`  in  1: a write beat is presented.
- `cfg_ready`  out  1: the loader can accept a beat.
- `cfg_addr`  in  3: target register.
  - 0 = b0, 1 = b1, 2 = b2, 3 = a1, 4 = a2, 5 = a3.
  - 6 = order (uses `cfg_data[3:0]`).
  - 7 = illegal.
- `cfg_data`  in  W: write data.
- `cfg_last`  in  1: this is the final beat of the transaction.
- `err_clr`  in  1: clears `cfg_err`.
- `b0`, `b1`, `b2`, `a1`, `a2`, `a3`  out  W each: active coefficients.
- `order`  out  4: active filter order.
- `filt_reset`  out  1: active-low synchronous reset to the filter.
- `commit_done`  out  1: one-cycle pulse when a commit completes.
- `cfg_err`  out  1: sticky flag for a rejected transaction.

## Operation
- **Storage.**
  - Shadow bank: 6×W coefficients plus a 4-bit order.
  - Active bank: same shape; drives the outputs directly from registers.
- **FSM states.** LOAD, CHECK, FLUSH.
- **LOAD**
  - `cfg_ready` = 1.
  - On `cfg_valid & cfg_ready`:
    - addr 0..6: write the shadow entry. Repeated writes to the same address: last wins.
    - addr 7: drop the data and set internal `bad_txn`.
    - If `cfg_last`: go to CHECK.
  - Addresses not written keep their shadow value, which equals the active value. Partial updates are therefore legal.
- **CHECK**, one cycle, `cfg_ready` = 0.
  - Commit if `bad_txn` = 0 and shadow order ∈ {1, 2, 3}:
    - Copy shadow to active.
    - `filt_reset` ← 0.
    - Counter ← `FLUSH_CYCLES` − 1.
    - Go to FLUSH.
  - Otherwise reject:
    - `cfg_err` ← 1.
    - Shadow ← active, discarding the transaction.
    - Go to LOAD.
  - In both cases `bad_txn` ← 0.
- **FLUSH**, `cfg_ready` = 0, `filt_reset` held 0.
  - Counter decrements each cycle.
  - At counter = 0 on the clock edge: `filt_reset` ← 1, `commit_done` ← 1 for one cycle, go to LOAD.
- **Error flag.** `cfg_err` is sticky and cleared by `err_clr`. A set event in the same cycle as `err_clr` wins, so the flag stays 1.
- **Order values.** 0 and 4..15 are never committed, so the active order is always 1..3 after the first commit.
- **No arithmetic.** The block only moves data: no truncation, no sign handling.

## Timing
- **Reset.** While `reset` = 0 at an edge:
  - State ← LOAD, counter ← 0.
  - All active and shadow coefficients ← 0, order ← 0.
  - `filt_reset` ← 0, `commit_done` ← 0, `cfg_err` ← 0, `bad_txn` ← 0.
  - `cfg_ready` = 0 while reset is asserted. It is 1 from the first cycle after reset deasserts.
  - `filt_reset` ← 1 on the first edge with `reset` = 1.
- **Commit latency.** If the last beat is accepted at edge E:
  - Cycle E..E+1 is CHECK.
  - Outputs update and `filt_reset` falls at edge E+1.
  - `filt_reset` stays low for exactly `FLUSH_CYCLES` cycles.
  - At edge E+1+`FLUSH_CYCLES`: `filt_reset` rises, `commit_done` pulses and `cfg_ready` returns to 1.
- **Reject latency.** `cfg_err` rises at edge E+1 and `cfg_ready` returns to 1 at edge E+1.
- **Handshake.**
  - `cfg_ready` is a pure function of state, with no combinational path from `cfg_valid`.
  - Beats presented while `cfg_ready` = 0 are not consumed; the master must hold them.
- **Reset mid-operation.** Reset in any state aborts immediately to reset values. An in-flight commit is lost, and the active bank returns to 0/order 0.
- **Back-to-back transactions.** Throughput is 1 beat per cycle in LOAD. A new transaction can start in the cycle `commit_done` is high.

## Test plan
- **Full load.** Reset, then write addr 0..5 = 0x0101..0x0606 and addr 6 = 2 with `cfg_last`.
  - Outputs update at E+1.
  - `filt_reset` is low for 4 cycles.
  - `commit_done` pulses at E+5 and `order` = 2.
- **Partial update.** After the full load, write only addr 1 = 0x7FFF with `cfg_last`.
  - `b1` = 0x7FFF.
  - All other coefficients are unchanged and `order` stays 2.
- **Illegal order.** Write addr 6 = 0 with `cfg_last`.
  - `cfg_err` = 1 at E+1.
  - Active bank unchanged, no `filt_reset` pulse.
  - A following partial write of `b0` commits with order still 2.
- **Illegal address.** Write addr 7 followed by addr 0 = 0x1234 with `cfg_last`.
  - Transaction rejected, `b0` unchanged, `cfg_err` = 1.
  - `err_clr` asserted in the same cycle as a new set event leaves `cfg_err` = 1.
- **Backpressure.** Hold `cfg_valid` high with a second transaction during CHECK/FLUSH.
  - No beat is consumed until `cfg_ready` = 1.
  - The second transaction then commits intact.
- **Reset mid-FLUSH.** Assert `reset` for 1 cycle during the third FLUSH cycle.
  - All outputs are at reset values at the next edge.
  - `filt_reset` = 1 one cycle after release.
  - No `commit_done`.
